// File: rtl/dimmer_channel_ctrl.sv
// dimmer_channel_ctrl: shares one rotary-encoder dimmer among N_CH PWM LED channels.
// Short button press selects the next channel, long press restores its default duty.
// Optional build macro SOFT_FADE_EN: shadow duties ramp toward their targets instead
// of jumping at each period boundary.
module dimmer_channel_ctrl #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CW           = 19,
    parameter int unsigned PERIOD       = 500_000,
    parameter int unsigned STEP         = 25_000,
    parameter int unsigned DEFAULT_DUTY = 250_000,
    parameter int unsigned LONG_PRESS   = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_up,
    input  logic                    step_dn,
    input  logic                    btn_n,
    output logic [$clog2(N_CH)-1:0] sel,
    output logic [CW-1:0]           duty_sel,
    output logic [N_CH-1:0]         pwm
);

    localparam int unsigned SW  = $clog2(N_CH);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned HW  = (LONG_PRESS > 1) ? $clog2(LONG_PRESS) : 1;
`ifdef SOFT_FADE_EN
    // A zero fade step would freeze the shadow forever, so never go below 1.
    localparam int unsigned FADE = ((STEP / 8) == 0) ? 1 : (STEP / 8);
    localparam logic [CW-1:0] FADE_C = CW'(FADE);
`endif

    localparam logic [CW-1:0]  CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0]  DEF_C     = CW'(DEFAULT_DUTY);
    localparam logic [CW:0]    PERIOD_W  = CW1'(PERIOD);
    localparam logic [CW:0]    STEP_W    = CW1'(STEP);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS - 1);
    localparam logic [SW-1:0]  SEL_LAST  = SW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        WAIT_REL = 2'd2
    } btn_state_t;

    btn_state_t      state, state_nxt;
    logic [HW-1:0]   hold;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   target [N_CH];
    logic [CW-1:0]   shadow [N_CH];
    logic [CW-1:0]   shadow_nxt_c [N_CH];
    logic            hold_clr_c, hold_inc_c, short_c, long_c;
    logic [CW:0]     inc_c, dec_c;
    logic [CW-1:0]   step_val_c;

    assign duty_sel = target[sel];

    // Button FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Button FSM next state and press strobes
    always_comb begin
        state_nxt  = state;
        hold_clr_c = 1'b0;
        hold_inc_c = 1'b0;
        short_c    = 1'b0;
        long_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!btn_n) begin
                    state_nxt  = PRESSED;
                    hold_clr_c = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_n && (hold == HOLD_LAST)) begin
                    long_c    = 1'b1;
                    state_nxt = WAIT_REL;
                end else if (btn_n) begin
                    short_c   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    hold_inc_c = 1'b1;
                end
            end
            WAIT_REL: begin
                if (btn_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Press-duration counter
    always_ff @(posedge clk) begin
        if (!rst_n || hold_clr_c) hold <= '0;
        else if (hold_inc_c)      hold <= hold + HW'(1);
    end

    // Channel selection, advanced by a short press
    always_ff @(posedge clk) begin
        if (!rst_n)       sel <= '0;
        else if (short_c) sel <= (sel == SEL_LAST) ? '0 : sel + SW'(1);
    end

    // Saturating step arithmetic one bit wider than the duty
    always_comb begin
        inc_c      = {1'b0, target[sel]} + STEP_W;
        dec_c      = {1'b0, target[sel]} - STEP_W;
        step_val_c = target[sel];
        if (step_up && !step_dn)
            step_val_c = (inc_c > PERIOD_W) ? CW'(PERIOD) : inc_c[CW-1:0];
        else if (step_dn && !step_up)
            step_val_c = dec_c[CW] ? '0 : dec_c[CW-1:0];
    end

    // Target duties: long press restores default, steps only while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) target[i] <= DEF_C;
        end else if (long_c) begin
            target[sel] <= DEF_C;
        end else if (state == IDLE) begin
            target[sel] <= step_val_c;
        end
    end

    // Shared period counter
    always_ff @(posedge clk) begin
        if (!rst_n || (cnt == CNT_LAST)) cnt <= '0;
        else                             cnt <= cnt + CW'(1);
    end

`ifdef SOFT_FADE_EN
    // Shadow approaches target by a bounded step without overshoot
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            shadow_nxt_c[i] = target[i];
            if (target[i] > shadow[i]) begin
                if ((target[i] - shadow[i]) > FADE_C) shadow_nxt_c[i] = shadow[i] + FADE_C;
            end else if (shadow[i] > target[i]) begin
                if ((shadow[i] - target[i]) > FADE_C) shadow_nxt_c[i] = shadow[i] - FADE_C;
            end
        end
    end
`else
    // Shadow takes the target directly
    always_comb begin
        for (int i = 0; i < N_CH; i++) shadow_nxt_c[i] = target[i];
    end
`endif

    // Shadow duties update only at the period boundary to avoid runt pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) shadow[i] <= DEF_C;
        end else if (cnt == CNT_LAST) begin
            for (int i = 0; i < N_CH; i++) shadow[i] <= shadow_nxt_c[i];
        end
    end

    // Registered PWM compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) pwm[i] <= (cnt < shadow[i]);
        end
    end

endmodule
